gray_wptr_full: RTL
===================

Name: gray_wptr_full

Overview:
Write-side pointer and full-flag stage of the team's asynchronous FIFO. Operates entirely in the write clock domain:
- Maintains the binary write address and a registered Gray-coded write pointer for export to the read domain.
- Synchronises the incoming Gray read pointer and generates full, almost_full and overflow flags.
- The synchronised Gray read pointer is also exported to feed a gray-to-binary decoder stage downstream (read-level accounting).

Parameters:
ADDR_WIDTH, 4, FIFO address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal range >= 2
SYNC_STAGES, 2, flops in the read-pointer synchroniser chain; legal range >= 2
AF_THRESH, 2, almost_full asserts when free slots <= AF_THRESH; legal range 1..depth-1

Ports:
clk  input  1  write-domain clock, rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  push request from producer
rd_ptr_gray  input  ADDR_WIDTH+1  Gray read pointer from read domain (asynchronous to clk)
wr_addr  output  ADDR_WIDTH  binary RAM write address (low bits of binary write pointer)
wr_ptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, to read domain
rd_ptr_gray_sync  output  ADDR_WIDTH+1  synchronised Gray read pointer (last sync stage)
push  output  1  combinational wr_en & ~full; RAM write strobe
full  output  1  registered full flag
almost_full  output  1  registered almost-full flag (see Optional Feature)
overflow  output  1  one-cycle registered pulse: wr_en asserted while full

Behaviour:
- Reset (async, asserts immediately, independent of clk): binary pointer, wr_ptr_gray, all sync stages, full, almost_full and overflow go to 0. Reset mid-operation discards all state; first edge after deassertion operates normally.
- Binary pointer wbin is ADDR_WIDTH+1 bits.
  - wbin_next = wbin + push; wraps modulo 2**(ADDR_WIDTH+1) with no saturation.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - Both wbin and wr_ptr_gray are registered on the same edge.
  - wr_ptr_gray changes by exactly one bit per push. No glitches: driven straight from a flop.
- wr_addr = wbin[ADDR_WIDTH-1:0]. wr_addr, push and the address used for the RAM write all refer to the same cycle.
- Synchroniser: rd_ptr_gray -> SYNC_STAGES flop chain; no logic between stages. rd_ptr_gray_sync = last stage.
- full_next = (wgray_next == {~rq[MSB:MSB-1], rq[MSB-2:0]}), where rq = rd_ptr_gray_sync. full is registered from full_next.
  - Asserts on the same edge as the push that fills the FIFO.
- Push while full: pointer does not move, push = 0, overflow = 1 for the next cycle. Data is dropped by producer contract.
- Full deasserts SYNC_STAGES+1 edges after a read-pointer change is stable at the input (conservative; never early).
- Simultaneous push and read-pointer advance in one cycle: full_next is evaluated with the current rq and the post-push pointer. Stale rq can only hold full longer, never release early.
- Empty state (wbin == rbin) has full = 0. Pointers equal except both MSBs of Gray differ = full.

Optional Feature:
Macro FIFO_ALMOST_FULL_EN.
- Defined:
  - Decodes rd_ptr_gray_sync to binary internally (MSB-first XOR chain).
  - used = (wbin_next - rbin_sync) mod 2**(ADDR_WIDTH+1).
  - almost_full registered = (used >= depth - AF_THRESH); resets to 0.
- Not defined: almost_full tied to 0. No decode or subtract logic is synthesised. The port stays present.

Test Plan:
- Reset, rd_ptr_gray = 0, hold wr_en = 0 -> wr_addr = 0, wr_ptr_gray = 0, full = 0, almost_full = 0, overflow = 0.
- ADDR_WIDTH = 4, rd_ptr_gray = 0, 16 back-to-back pushes:
  - wr_ptr_gray sequence 1, 3, 2, 6, 7, 5, 4, 12, ...
  - full rises on the 16th push edge; wr_ptr_gray = 5'b11000.
  - With FIFO_ALMOST_FULL_EN: almost_full rises on the 14th push.
- While full, wr_en = 1 for 3 cycles -> push = 0, wr_addr stays 0, overflow high for 3 cycles, then 0 one cycle after wr_en drops.
- From full, set rd_ptr_gray = 5'b00001 -> full clears exactly 3 edges later (SYNC_STAGES = 2); next push writes wr_addr = 0.
- 40 pushes with rd_ptr_gray tracking 4 behind (stepped in Gray) -> binary pointer wraps 31 -> 0; full never asserts; wr_ptr_gray MSB toggles at 16 and 32.
- Assert rst mid-burst asynchronously (between edges) -> all outputs 0 immediately; pushes resume from wr_addr = 0 after release.

Source files
------------

// File: rtl/gray_wptr_full_if.sv
// Write-side pointer bundle of the async FIFO: producer push request, read-pointer input,
// and the address, Gray pointer and flag outputs of gray_wptr_full.
interface gray_wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   rd_ptr_gray;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   wr_ptr_gray;
  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync;
  logic                  push;
  logic                  full;
  logic                  almost_full;
  logic                  overflow;

  modport master (
    output wr_en, rd_ptr_gray,
    input  wr_addr, wr_ptr_gray, rd_ptr_gray_sync, push, full, almost_full, overflow
  );

  modport slave (
    input  wr_en, rd_ptr_gray,
    output wr_addr, wr_ptr_gray, rd_ptr_gray_sync, push, full, almost_full, overflow
  );
endinterface

// File: rtl/gray_wptr_full.sv
// Write-domain pointer stage of the async FIFO: binary/Gray write pointer, read-pointer
// synchroniser, full and overflow flags. Define FIFO_ALMOST_FULL_EN to build almost_full.
module gray_wptr_full #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 2
) (
  input logic             clk,
  input logic             rst,
  gray_wptr_full_if.slave bus
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [PW-1:0] wbin, wbin_next;
  logic [PW-1:0] wgray, wgray_next;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rq, full_cmp;
  logic          full_q, full_next;
  logic          overflow_q;

  assign rq       = sync_q[SYNC_STAGES-1];
  assign bus.push = bus.wr_en & ~full_q;

  // Full when the next write pointer equals the read pointer with both Gray MSBs inverted.
  always_comb begin
    wbin_next  = wbin + PW'(bus.push);
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    full_cmp   = {~rq[PW-1:PW-2], rq[PW-3:0]};
    full_next  = (wgray_next == full_cmp);
  end

  // NOTE: non-blocking assignments so each stage captures its predecessor's pre-edge value;
  // the chain is ordinary flops, so it takes the async reset like the rest of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin       <= '0;
      wgray      <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wbin       <= wbin_next;
      wgray      <= wgray_next;
      full_q     <= full_next;
      overflow_q <= bus.wr_en & full_q;
    end
  end

  assign bus.wr_addr          = wbin[ADDR_WIDTH-1:0];
  assign bus.wr_ptr_gray      = wgray;
  assign bus.rd_ptr_gray_sync = rq;
  assign bus.full             = full_q;
  assign bus.overflow         = overflow_q;

`ifdef FIFO_ALMOST_FULL_EN
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] used;
  logic          af_q;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i < PW; i++) rbin_sync[i] = ^(rq >> i);
    used = wbin_next - rbin_sync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) af_q <= 1'b0;
    else     af_q <= (used >= PW'(DEPTH - AF_THRESH));
  end

  assign bus.almost_full = af_q;
`else
  assign bus.almost_full = 1'b0;
`endif
endmodule
